mac_driver: RTL



---
 rtl/mac_driver_if.sv | 48 ++++
 rtl/mac_driver.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mac_driver_if.sv
// mac_driver_if: bundles every non-clock/reset signal of mac_driver.
//   master : the driver side (mac_driver itself).
//   slave  : the environment (operand fetch, MAC instance, result writeback).
// Signals: job request (start, cfg_len, cfg_bias, busy), operand stream
// (op_valid/op_ready/op_a/op_b), MAC pins (mac_*), result stream
// (res_valid/res_ready/res_data/res_sat).
interface mac_driver_if #(
  parameter int unsigned A_WIDTH           = 8,
  parameter int unsigned B_WIDTH           = 8,
  parameter int unsigned ACCUMULATOR_WIDTH = 16,
  parameter int unsigned OUTPUT_WIDTH      = 8,
  parameter int unsigned MAX_LEN           = 256,
  parameter int unsigned LEN_WIDTH         = $clog2(MAX_LEN + 1)
);
  logic                         start;
  logic [LEN_WIDTH-1:0]         cfg_len;
  logic [ACCUMULATOR_WIDTH-1:0] cfg_bias;
  logic                         busy;

  logic                         op_valid;
  logic                         op_ready;
  logic [A_WIDTH-1:0]           op_a;
  logic [B_WIDTH-1:0]           op_b;

  logic                         mac_input_valid;
  logic                         mac_accumulate_internal;
  logic [ACCUMULATOR_WIDTH-1:0] mac_partial_sum_in;
  logic [A_WIDTH-1:0]           mac_a;
  logic [B_WIDTH-1:0]           mac_b;
  logic [ACCUMULATOR_WIDTH-1:0] mac_acc;

  logic                         res_valid;
  logic                         res_ready;
  logic [OUTPUT_WIDTH-1:0]      res_data;
  logic                         res_sat;

  modport master (
    input  start, cfg_len, cfg_bias, op_valid, op_a, op_b, mac_acc, res_ready,
    output busy, op_ready, mac_input_valid, mac_accumulate_internal, mac_partial_sum_in,
           mac_a, mac_b, res_valid, res_data, res_sat
  );

  modport slave (
    output start, cfg_len, cfg_bias, op_valid, op_a, op_b, mac_acc, res_ready,
    input  busy, op_ready, mac_input_valid, mac_accumulate_internal, mac_partial_sum_in,
           mac_a, mac_b, res_valid, res_data, res_sat
  );
endinterface

// File: rtl/mac_driver.sv
// mac_driver: sequences one job of cfg_len operand pairs into a MAC, then reads the MAC
// accumulator, rescales (round half toward +inf), saturates and offers it as a result.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mac_driver_if.master: job request, operand stream, MAC pins, result stream
module mac_driver #(
  parameter int unsigned A_WIDTH           = 8,
  parameter int unsigned B_WIDTH           = 8,
  parameter int unsigned ACCUMULATOR_WIDTH = 16,
  parameter int unsigned OUTPUT_WIDTH      = 8,
  parameter int unsigned OUTPUT_SCALE      = 0,
  parameter int unsigned MAX_LEN           = 256
) (
  input logic          clk,
  input logic          rst,
  mac_driver_if.master bus
);
  localparam int unsigned LenWidth = $clog2(MAX_LEN + 1);
  // One guard bit so the rounding add cannot overflow.
  localparam int unsigned ExtWidth = ACCUMULATOR_WIDTH + 1;
  localparam logic signed [ExtWidth-1:0] MaxV = ExtWidth'((1 << (OUTPUT_WIDTH - 1)) - 1);
  localparam logic signed [ExtWidth-1:0] MinV = ~MaxV;

  typedef enum logic [1:0] {StIdle, StRun, StWait, StOut} state_e;

  state_e                       state_q;
  logic [LenWidth-1:0]          len_q;
  logic [LenWidth-1:0]          count_q;
  logic [ACCUMULATOR_WIDTH-1:0] bias_q;
  logic                         bias_sel_q;
  logic [OUTPUT_WIDTH-1:0]      res_data_q;
  logic                         res_sat_q;

  logic                         op_fire;
  logic                         last_op;
  logic [ACCUMULATOR_WIDTH-1:0] acc_sel;
  logic signed [ExtWidth-1:0]   acc_ext;
  logic signed [ExtWidth-1:0]   acc_rnd;
  logic                         sat_hi;
  logic                         sat_lo;
  logic [OUTPUT_WIDTH-1:0]      res_next;

  assign op_fire = (state_q == StRun) && bus.op_valid;
  assign last_op = (count_q == len_q - LenWidth'(1));

  // Zero-length jobs never touch the MAC, so the bias is the result.
  assign acc_sel = bias_sel_q ? bias_q : bus.mac_acc;
  assign acc_ext = {acc_sel[ACCUMULATOR_WIDTH-1], acc_sel};

  if (OUTPUT_SCALE > 0) begin : g_scale
    localparam logic signed [ExtWidth-1:0] RoundHalf = ExtWidth'(1) << (OUTPUT_SCALE - 1);
    logic signed [ExtWidth-1:0] acc_sum;
    assign acc_sum = acc_ext + RoundHalf;
    assign acc_rnd = acc_sum >>> OUTPUT_SCALE;
  end else begin : g_noscale
    assign acc_rnd = acc_ext;
  end

  assign sat_hi   = acc_rnd > MaxV;
  assign sat_lo   = acc_rnd < MinV;
  assign res_next = sat_hi ? MaxV[OUTPUT_WIDTH-1:0] :
                    sat_lo ? MinV[OUTPUT_WIDTH-1:0] : acc_rnd[OUTPUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      count_q    <= '0;
      bias_q     <= '0;
      bias_sel_q <= 1'b0;
      res_data_q <= '0;
      res_sat_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            len_q      <= bus.cfg_len;
            bias_q     <= bus.cfg_bias;
            count_q    <= '0;
            bias_sel_q <= (bus.cfg_len == '0);
            state_q    <= (bus.cfg_len == '0) ? StWait : StRun;
          end
        end
        StRun: begin
          if (bus.op_valid) begin
            count_q <= count_q + LenWidth'(1);
            if (last_op) state_q <= StWait;
          end
        end
        StWait: begin
          res_data_q <= res_next;
          res_sat_q  <= sat_hi | sat_lo;
          state_q    <= StOut;
        end
        StOut: begin
          if (bus.res_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.op_ready  = (state_q == StRun);
  assign bus.res_valid = (state_q == StOut);
  assign bus.res_data  = res_data_q;
  assign bus.res_sat   = res_sat_q;

  always_comb begin
    bus.mac_input_valid         = 1'b0;
    bus.mac_accumulate_internal = 1'b0;
    bus.mac_partial_sum_in      = '0;
    bus.mac_a                   = '0;
    bus.mac_b                   = '0;
    if (op_fire) begin
      bus.mac_input_valid         = 1'b1;
      // First term loads bias + product; the MAC's stale accumulator is ignored.
      bus.mac_accumulate_internal = (count_q != '0);
      bus.mac_partial_sum_in      = bias_q;
      bus.mac_a                   = bus.op_a;
      bus.mac_b                   = bus.op_b;
    end
  end
endmodule
